execute_stage: RTL and testbench

- Y86-64 pipeline Execute stage, between the D/E pipeline register (upstream) and Memory (downstream).
- Selects ALU operands and function, and drives an instance of alu_block.
- Owns the condition-code register (ZF/SF/OF) and evaluates Cnd for cmovXX/jXX.
- Registers results into the E/M pipeline register (M_* outputs), with bubble/stall control.

---
 rtl/y86_pkg.sv | 43 ++++
 rtl/alu_block.sv | 29 ++
 rtl/execute_stage_cond_eval.sv | 24 ++
 rtl/execute_stage.sv | 143 ++++++++++++++
 tb/tb_execute_stage.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU function codes,
// stage status codes, and the ALU select mapping used by execute_stage.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    // ALU function codes as encoded in ifun of OPq
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    // Stage status codes
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    // alu_block select encoding differs from the ISA ordering: and/xor are swapped
    function automatic logic [1:0] alu_sel(input logic [3:0] fun);
        case (fun)
            ALU_SUB: alu_sel = 2'b01;
            ALU_XOR: alu_sel = 2'b10;
            ALU_AND: alu_sel = 2'b11;
            default: alu_sel = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/alu_block.sv
// Two-operand ALU: S=00 add, 01 sub (A-B), 10 xor, 11 and.
// OF reports signed overflow for add/sub and is 0 for logic ops.
module alu_block #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       S,
    output logic [WIDTH-1:0] Y,
    output logic             OF
);
    // Result and signed overflow
    always_comb begin
        Y  = '0;
        OF = 1'b0;
        case (S)
            2'b00: begin
                Y  = A + B;
                OF = (A[WIDTH-1] == B[WIDTH-1]) && (Y[WIDTH-1] != A[WIDTH-1]);
            end
            2'b01: begin
                Y  = A - B;
                OF = (A[WIDTH-1] != B[WIDTH-1]) && (Y[WIDTH-1] != A[WIDTH-1]);
            end
            2'b10:   Y = A ^ B;
            default: Y = A & B;
        endcase
    end
endmodule

// File: rtl/execute_stage_cond_eval.sv
// Branch / conditional-move condition evaluation from {ZF,SF,OF} and ifun.
module cond_eval (
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd
);
    logic zf, sf, of;
    assign {zf, sf, of} = cc;

    // Condition table; unknown ifun never fires
    always_comb begin
        cnd = 1'b0;
        case (ifun)
            4'd0: cnd = 1'b1;
            4'd1: cnd = (sf ^ of) | zf;
            4'd2: cnd = sf ^ of;
            4'd3: cnd = zf;
            4'd4: cnd = ~zf;
            4'd5: cnd = ~(sf ^ of);
            4'd6: cnd = ~(sf ^ of) & ~zf;
            default: cnd = 1'b0;
        endcase
    end
endmodule

// File: rtl/execute_stage.sv
// Y86-64 Execute stage: operand select, ALU, condition codes, Cnd and the
// E/M pipeline register. Optional CC-update counter under EXEC_CC_COUNT_EN.
module execute_stage
    import y86_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       E_stat,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_ifun,
    input  logic [WIDTH-1:0] E_valA,
    input  logic [WIDTH-1:0] E_valB,
    input  logic [WIDTH-1:0] E_valC,
    input  logic [3:0]       E_dstE,
    input  logic [3:0]       E_dstM,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    input  logic             M_bubble,
    input  logic             M_stall,
    output logic [WIDTH-1:0] e_valE,
    output logic [3:0]       e_dstE,
    output logic             e_Cnd,
    output logic [2:0]       M_stat,
    output logic [3:0]       M_icode,
    output logic             M_Cnd,
    output logic [WIDTH-1:0] M_valE,
    output logic [WIDTH-1:0] M_valA,
    output logic [3:0]       M_dstE,
    output logic [3:0]       M_dstM,
    output logic [2:0]       cc_out,
    output logic [CNT_W-1:0] cc_upd_cnt
);

    typedef struct packed {
        logic [2:0]       stat;
        logic [3:0]       icode;
        logic             cnd;
        logic [WIDTH-1:0] valE;
        logic [WIDTH-1:0] valA;
        logic [3:0]       dstE;
        logic [3:0]       dstM;
    } em_t;

    localparam em_t EM_NOP = '{stat: S_AOK, icode: I_NOP, cnd: 1'b0,
                               valE: '0, valA: '0, dstE: RNONE, dstM: RNONE};

    logic [WIDTH-1:0] alu_a, alu_b;
    logic [3:0]       alu_fun;
    logic             alu_of;
    logic             set_cc;
    logic [2:0]       cc_q, cc_d;
    em_t              em_q, em_d;

    // aluA / aluB operand selection
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (E_icode)
            I_OPQ, I_CMOV:             alu_a = E_valA;
            I_IRMOV, I_RMMOV, I_MRMOV: alu_a = E_valC;
            I_CALL, I_PUSH:            alu_a = '0 - WIDTH'(8);
            I_RET, I_POP:              alu_a = WIDTH'(8);
            default:                   alu_a = '0;
        endcase
        case (E_icode)
            I_OPQ, I_RMMOV, I_MRMOV, I_CALL,
            I_PUSH, I_RET, I_POP:      alu_b = E_valB;
            default:                   alu_b = '0;
        endcase
    end

    assign alu_fun = (E_icode == I_OPQ) ? E_ifun : ALU_ADD;

    // Operands swapped so subq computes valB - valA
    alu_block #(.WIDTH(WIDTH)) u_alu (
        .A  (alu_b),
        .B  (alu_a),
        .S  (alu_sel(alu_fun)),
        .Y  (e_valE),
        .OF (alu_of)
    );

    cond_eval u_cond (
        .cc   (cc_q),
        .ifun (E_ifun),
        .cnd  (e_Cnd)
    );

    assign e_dstE = (E_icode == I_CMOV && !e_Cnd) ? RNONE : E_dstE;

    // CC only change for OPq when no exception is already downstream
    assign set_cc = (E_icode == I_OPQ) && (m_stat == S_AOK) && (W_stat == S_AOK);
    assign cc_d   = {(e_valE == '0), e_valE[WIDTH-1], alu_of};

    // Condition-code register; independent of E/M stall/bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cc_q <= 3'b100;
        else if (set_cc) cc_q <= cc_d;
    end

    // E/M next-state: bubble beats stall
    always_comb begin
        em_d = em_q;
        if (M_bubble)
            em_d = EM_NOP;
        else if (!M_stall)
            em_d = '{stat: E_stat, icode: E_icode, cnd: e_Cnd, valE: e_valE,
                     valA: E_valA, dstE: e_dstE, dstM: E_dstM};
    end

    // E/M pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) em_q <= EM_NOP;
        else        em_q <= em_d;
    end

    assign M_stat  = em_q.stat;
    assign M_icode = em_q.icode;
    assign M_Cnd   = em_q.cnd;
    assign M_valE  = em_q.valE;
    assign M_valA  = em_q.valA;
    assign M_dstE  = em_q.dstE;
    assign M_dstM  = em_q.dstM;
    assign cc_out  = cc_q;

`ifdef EXEC_CC_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Count edges on which the condition codes are written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt_q <= '0;
        else if (set_cc) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign cc_upd_cnt = cnt_q;
`else
    assign cc_upd_cnt = '0;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares the masked fields.
module tb_execute_stage;

    localparam int WIDTH = 64;
    localparam int CNT_W = 32;
`ifdef EXEC_CC_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk, rst_n;
    logic [2:0]       E_stat, m_stat, W_stat;
    logic [3:0]       E_icode, E_ifun, E_dstE, E_dstM;
    logic [WIDTH-1:0] E_valA, E_valB, E_valC;
    logic             M_bubble, M_stall;
    logic [WIDTH-1:0] e_valE, M_valE, M_valA;
    logic [3:0]       e_dstE, M_icode, M_dstE, M_dstM;
    logic             e_Cnd, M_Cnd;
    logic [2:0]       M_stat, cc_out;
    logic [CNT_W-1:0] cc_upd_cnt;

    execute_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .m_stat(m_stat), .W_stat(W_stat),
        .M_bubble(M_bubble), .M_stall(M_stall),
        .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .cc_out(cc_out), .cc_upd_cnt(cc_upd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_EVALE = 1,  K_EDSTE = 2,  K_ECND  = 4,   K_MICODE = 8;
    localparam int K_MSTAT = 16, K_MCND  = 32, K_MVALE = 64,  K_MVALA  = 128;
    localparam int K_MDSTE = 256, K_MDSTM = 512, K_CC = 1024, K_CNT    = 2048;

    typedef struct {
        string       name;
        int          mask;
        logic [63:0] evale;
        logic [3:0]  edste;
        logic        ecnd;
        logic [3:0]  micode;
        logic [2:0]  mstat;
        logic        mcnd;
        logic [63:0] mvale;
        logic [63:0] mvala;
        logic [3:0]  mdste;
        logic [3:0]  mdstm;
        logic [2:0]  cc;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t ex;
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic void cmp(string tag, string fld, logic [63:0] act, logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s got=%h want=%h", tag, fld, act, req);
        end
    endfunction

    // Monitor: sample away from the active edge and check the oldest expectation
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.mask & K_EVALE)  cmp(e.name, "e_valE",  e_valE,  e.evale);
            if (e.mask & K_EDSTE)  cmp(e.name, "e_dstE",  64'(e_dstE),  64'(e.edste));
            if (e.mask & K_ECND)   cmp(e.name, "e_Cnd",   64'(e_Cnd),   64'(e.ecnd));
            if (e.mask & K_MICODE) cmp(e.name, "M_icode", 64'(M_icode), 64'(e.micode));
            if (e.mask & K_MSTAT)  cmp(e.name, "M_stat",  64'(M_stat),  64'(e.mstat));
            if (e.mask & K_MCND)   cmp(e.name, "M_Cnd",   64'(M_Cnd),   64'(e.mcnd));
            if (e.mask & K_MVALE)  cmp(e.name, "M_valE",  M_valE,  e.mvale);
            if (e.mask & K_MVALA)  cmp(e.name, "M_valA",  M_valA,  e.mvala);
            if (e.mask & K_MDSTE)  cmp(e.name, "M_dstE",  64'(M_dstE),  64'(e.mdste));
            if (e.mask & K_MDSTM)  cmp(e.name, "M_dstM",  64'(M_dstM),  64'(e.mdstm));
            if (e.mask & K_CC)     cmp(e.name, "cc_out",  64'(cc_out),  64'(e.cc));
            if (e.mask & K_CNT)    cmp(e.name, "cc_upd_cnt", 64'(cc_upd_cnt), 64'(e.cnt));
        end
    end

    task automatic new_exp(input string name);
        ex = '{name: name, mask: 0, evale: '0, edste: '0, ecnd: 1'b0, micode: '0,
               mstat: '0, mcnd: 1'b0, mvale: '0, mvala: '0, mdste: '0, mdstm: '0,
               cc: '0, cnt: '0};
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic [3:0] de, input logic [3:0] dm);
        E_stat = 3'd1; E_icode = ic; E_ifun = fn;
        E_valA = a; E_valB = b; E_valC = c; E_dstE = de; E_dstM = dm;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] cexp(input int n);
        return CNT_ON ? 32'(n) : 32'd0;
    endfunction

    initial begin
        rst_n = 1'b0; M_bubble = 1'b0; M_stall = 1'b0;
        m_stat = 3'd1; W_stat = 3'd1;
        drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
        step; step;
        rst_n = 1'b1;

        // A: subq 5-5 ; E/M still in reset state
        drive(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h3, 4'hF);
        new_exp("sub_eq");
        ex.mask = K_EVALE | K_EDSTE | K_ECND | K_MICODE | K_MSTAT | K_MDSTE | K_MDSTM | K_CC | K_CNT;
        ex.evale = 64'd0; ex.edste = 4'h3; ex.ecnd = 1'b1;
        ex.micode = 4'h1; ex.mstat = 3'd1; ex.mdste = 4'hF; ex.mdstm = 4'hF; ex.cc = 3'b100; ex.cnt = 0;
        sb.push_back(ex);
        step;

        // B: subq registered; addq overflow
        drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h4, 4'hF);
        new_exp("add_ovf");
        ex.mask = K_EVALE | K_MICODE | K_MSTAT | K_MCND | K_MVALE | K_MVALA | K_MDSTE | K_CC | K_CNT;
        ex.evale = 64'h8000_0000_0000_0000;
        ex.micode = 4'h6; ex.mstat = 3'd1; ex.mcnd = 1'b1; ex.mvale = 64'd0; ex.mvala = 64'd5;
        ex.mdste = 4'h3; ex.cc = 3'b100; ex.cnt = cexp(1);
        sb.push_back(ex);
        step;

        // C: CC={0,1,1}; cmovl not taken
        drive(4'h2, 4'h2, 64'h55, 64'h99, 64'd0, 4'h5, 4'hF);
        new_exp("cmovl");
        ex.mask = K_EVALE | K_EDSTE | K_ECND | K_MVALE | K_MDSTE | K_CC | K_CNT;
        ex.evale = 64'h55; ex.edste = 4'hF; ex.ecnd = 1'b0;
        ex.mvale = 64'h8000_0000_0000_0000; ex.mdste = 4'h4; ex.cc = 3'b011; ex.cnt = cexp(2);
        sb.push_back(ex);
        step;

        // D: andq with W_stat=HLT -> CC must not change
        W_stat = 3'd2;
        drive(4'h6, 4'h2, 64'hF0F0, 64'h0FF0, 64'd0, 4'h6, 4'hF);
        new_exp("and_blk");
        ex.mask = K_EVALE | K_MICODE | K_MCND | K_MVALE | K_MVALA | K_MDSTE | K_CC;
        ex.evale = 64'h00F0; ex.micode = 4'h2; ex.mcnd = 1'b0; ex.mvale = 64'h55;
        ex.mvala = 64'h55; ex.mdste = 4'hF; ex.cc = 3'b011;
        sb.push_back(ex);
        step;

        // E: pushq
        W_stat = 3'd1;
        drive(4'hA, 4'h0, 64'h1234, 64'h100, 64'd0, 4'h4, 4'hF);
        new_exp("push");
        ex.mask = K_EVALE | K_MICODE | K_MVALE | K_MDSTE | K_CC | K_CNT;
        ex.evale = 64'hF8; ex.micode = 4'h6; ex.mvale = 64'h00F0; ex.mdste = 4'h6;
        ex.cc = 3'b011; ex.cnt = cexp(2);
        sb.push_back(ex);
        step;

        // F: popq
        drive(4'hB, 4'h0, 64'h0, 64'h100, 64'd0, 4'h4, 4'h3);
        new_exp("pop");
        ex.mask = K_EVALE | K_MICODE | K_MVALE | K_MVALA | K_CC;
        ex.evale = 64'h108; ex.micode = 4'hA; ex.mvale = 64'hF8; ex.mvala = 64'h1234; ex.cc = 3'b011;
        sb.push_back(ex);
        step;

        // G: xorq with m_stat=ADR, plus bubble+stall together
        m_stat = 3'd3; M_bubble = 1'b1; M_stall = 1'b1;
        drive(4'h6, 4'h3, 64'hFF, 64'h0F, 64'd0, 4'h7, 4'hF);
        new_exp("xor_blk");
        ex.mask = K_EVALE | K_MICODE | K_MVALE | K_MDSTM | K_CC;
        ex.evale = 64'hF0; ex.micode = 4'hB; ex.mvale = 64'h108; ex.mdstm = 4'h3; ex.cc = 3'b011;
        sb.push_back(ex);
        step;

        // H: bubble result; irmovq ignores valB
        m_stat = 3'd1; M_bubble = 1'b0; M_stall = 1'b0;
        drive(4'h3, 4'h0, 64'h0, 64'h999, 64'h42, 4'h2, 4'hF);
        new_exp("bubble");
        ex.mask = K_EVALE | K_MICODE | K_MSTAT | K_MCND | K_MVALE | K_MDSTE | K_MDSTM | K_CC | K_CNT;
        ex.evale = 64'h42; ex.micode = 4'h1; ex.mstat = 3'd1; ex.mcnd = 1'b0; ex.mvale = 64'd0;
        ex.mdste = 4'hF; ex.mdstm = 4'hF; ex.cc = 3'b011; ex.cnt = cexp(2);
        sb.push_back(ex);
        step;

        // I: irmovq registered; stall begins, subq 1-3 still updates CC
        M_stall = 1'b1;
        drive(4'h6, 4'h1, 64'd3, 64'd1, 64'd0, 4'h9, 4'hF);
        new_exp("stall0");
        ex.mask = K_EVALE | K_MICODE | K_MVALE | K_MDSTE;
        ex.evale = 64'hFFFF_FFFF_FFFF_FFFE; ex.micode = 4'h3; ex.mvale = 64'h42; ex.mdste = 4'h2;
        sb.push_back(ex);
        step;

        // J..L: held for three cycles while E_* change
        drive(4'h5, 4'h0, 64'h0, 64'h20, 64'h10, 4'hF, 4'h8);
        new_exp("stall1");
        ex.mask = K_EVALE | K_MICODE | K_MVALE | K_MDSTE | K_CC | K_CNT;
        ex.evale = 64'h30; ex.micode = 4'h3; ex.mvale = 64'h42; ex.mdste = 4'h2;
        ex.cc = 3'b010; ex.cnt = cexp(3);
        sb.push_back(ex);
        step;

        drive(4'h2, 4'h1, 64'd7, 64'h0, 64'd0, 4'h8, 4'hF);
        new_exp("stall2");
        ex.mask = K_EVALE | K_EDSTE | K_ECND | K_MICODE | K_MVALE | K_MDSTE;
        ex.evale = 64'd7; ex.edste = 4'h8; ex.ecnd = 1'b1;
        ex.micode = 4'h3; ex.mvale = 64'h42; ex.mdste = 4'h2;
        sb.push_back(ex);
        step;

        M_stall = 1'b0;
        drive(4'h7, 4'h4, 64'h123, 64'h0, 64'h400, 4'hF, 4'hF);
        new_exp("stall3");
        ex.mask = K_EVALE | K_ECND | K_MICODE | K_MVALE | K_MDSTE | K_CC;
        ex.evale = 64'd0; ex.ecnd = 1'b1; ex.micode = 4'h3; ex.mvale = 64'h42; ex.mdste = 4'h2;
        ex.cc = 3'b010;
        sb.push_back(ex);
        step;

        // M: jne registered; jXX with ifun 7 never taken
        drive(4'h7, 4'h7, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
        new_exp("jxx");
        ex.mask = K_ECND | K_MICODE | K_MCND | K_MVALE | K_MVALA;
        ex.ecnd = 1'b0; ex.micode = 4'h7; ex.mcnd = 1'b1; ex.mvale = 64'd0; ex.mvala = 64'h123;
        sb.push_back(ex);
        step;

        // N: asynchronous reset mid-cycle
        rst_n = 1'b0;
        new_exp("reset");
        ex.mask = K_MICODE | K_MSTAT | K_MCND | K_MVALE | K_MVALA | K_MDSTE | K_MDSTM | K_CC | K_CNT;
        ex.micode = 4'h1; ex.mstat = 3'd1; ex.mcnd = 1'b0; ex.mvale = 64'd0; ex.mvala = 64'd0;
        ex.mdste = 4'hF; ex.mdstm = 4'hF; ex.cc = 3'b100; ex.cnt = 0;
        sb.push_back(ex);
        step;
        rst_n = 1'b1;

        // drain with a bounded wait
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
